// File: rtl/ov_pkg.sv
// Shared definitions for the OV7670 -> AL422 capture path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ov_pkg;

  // Frame geometry: QVGA, RGB565 (two bytes per pixel).
  localparam int FRAME_W       = 320;
  localparam int FRAME_H       = 240;
  localparam int BYTES_PER_PIX = 2;
  localparam int FRAME_BYTES   = FRAME_W * FRAME_H * BYTES_PER_PIX;

  // 100 ms at 25 MHz; also used by the read-side controller.
  localparam int TIMEOUT_DEF = 2500000;

  // Write controller states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_WRST  = 3'd2;
  localparam logic [2:0] ST_ARM   = 3'd3;
  localparam logic [2:0] ST_CAPT  = 3'd4;
  localparam logic [2:0] ST_READY = 3'd5;
  localparam logic [2:0] ST_BUSY  = 3'd6;

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchronizer plus a third stage for rise/fall strobe detection.
// Latency: strobes act on the 3rd clock edge after the input edge.
// Backpressure: none; strobes are single-cycle and never stall.
module sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sh_q;

  // Shift the asynchronous input through the synchronizer and history stage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_q <= 3'b000;
    end else begin
      sh_q <= {sh_q[1:0], d_i};
    end
  end

  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/ov_write.sv
// Gates camera frames into the AL422 FIFO from VSYNC timing, then holds until the reader drains it.
// Latency: fifo_wrst/fifo_wen react one edge after the synchronized VSYNC strobe.
// Backpressure: no new capture starts until frame_read has gone low and back high.
module ov_write import ov_pkg::*; #(
  parameter int WRST_CYCLES = 4,
  parameter int SKIP_FRAMES = 2,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       initialized,
  input  logic       vsync,
  input  logic       frame_read,
  output logic       new_frame,
  output logic       fifo_wen,
  output logic       fifo_wrst,
  output logic       timeout,
  output logic [7:0] frame_count
);

  localparam logic [7:0]  SKIP_INIT = 8'(SKIP_FRAMES);
  localparam logic [7:0]  HOLD_INIT = 8'(WRST_CYCLES - 1);
  localparam logic [21:0] WD_LAST   = 22'(TIMEOUT - 1);

  logic        vs_rise, vs_fall;
  logic [2:0]  state_q, state_d;
  logic [7:0]  skip_q, skip_d;
  logic [7:0]  hold_q, hold_d;
  logic [21:0] wdog_q, wdog_d;
  logic        fall_pend_q, fall_pend_d;
  logic        new_frame_q, new_frame_d;
  logic        wen_q, wen_d;
  logic        wrst_q, wrst_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  count_q, count_d;
  logic        wd_active, wd_expire, abort;

  sync_edge u_vs_sync (
    .clk_i   (clk_25MHz),
    .rst_n_i (rst_n),
    .d_i     (vsync),
    .rise_o  (vs_rise),
    .fall_o  (vs_fall)
  );

  // The watchdog only runs while we are expecting VSYNC edges; any edge wins over expiry.
  assign wd_active = (state_q == ST_SYNC) || (state_q == ST_ARM) || (state_q == ST_CAPT);
  assign wd_expire = wd_active && !vs_rise && !vs_fall && (wdog_q == WD_LAST);

  // Next-state logic for the capture sequence, watchdog and reader handshake.
  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    hold_d      = hold_q;
    fall_pend_d = fall_pend_q;
    new_frame_d = new_frame_q;
    wen_d       = wen_q;
    wrst_d      = wrst_q;
    count_d     = count_q;
    timeout_d   = 1'b0;
    abort       = 1'b0;
    wdog_d      = (wd_active && !vs_rise && !vs_fall) ? (wdog_q + 22'd1) : 22'd0;

    if (!initialized) begin
      // Camera lost its configuration: drop everything and re-skip the settling frames.
      state_d     = ST_IDLE;
      wen_d       = 1'b0;
      wrst_d      = 1'b1;
      new_frame_d = 1'b0;
      skip_d      = SKIP_INIT;
      fall_pend_d = 1'b0;
      wdog_d      = 22'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_read) state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (vs_rise) begin
            if (skip_q != 8'd0) begin
              skip_d = skip_q - 8'd1;
            end else begin
              wrst_d      = 1'b0;
              hold_d      = HOLD_INIT;
              fall_pend_d = 1'b0;
              state_d     = ST_WRST;
            end
          end else if (wd_expire) begin
            abort = 1'b1;
          end
        end
        ST_WRST: begin
          // A short VSYNC pulse can end while the pointer reset is still held.
          if (vs_fall) fall_pend_d = 1'b1;
          if (hold_q == 8'd0) begin
            wrst_d  = 1'b1;
            state_d = ST_ARM;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
        ST_ARM: begin
          if (vs_fall || fall_pend_q) begin
            wen_d       = 1'b1;
            fall_pend_d = 1'b0;
            wdog_d      = 22'd0;
            state_d     = ST_CAPT;
          end else if (wd_expire) begin
            abort = 1'b1;
          end
        end
        ST_CAPT: begin
          if (vs_rise) begin
            wen_d       = 1'b0;
            count_d     = count_q + 8'd1;
            new_frame_d = 1'b1;
            state_d     = ST_READY;
          end else if (wd_expire) begin
            abort = 1'b1;
          end
        end
        ST_READY: begin
          if (!frame_read) begin
            new_frame_d = 1'b0;
            state_d     = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (frame_read) state_d = ST_IDLE;
        end
        default: begin
          state_d     = ST_IDLE;
          wen_d       = 1'b0;
          wrst_d      = 1'b1;
          new_frame_d = 1'b0;
        end
      endcase

      if (abort) begin
        wen_d       = 1'b0;
        wrst_d      = 1'b1;
        timeout_d   = 1'b1;
        fall_pend_d = 1'b0;
        wdog_d      = 22'd0;
        state_d     = ST_IDLE;
      end
    end
  end

  // State and registered outputs; reset forces the FIFO strobes safe immediately.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      skip_q      <= SKIP_INIT;
      hold_q      <= 8'd0;
      wdog_q      <= 22'd0;
      fall_pend_q <= 1'b0;
      new_frame_q <= 1'b0;
      wen_q       <= 1'b0;
      wrst_q      <= 1'b1;
      timeout_q   <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      hold_q      <= hold_d;
      wdog_q      <= wdog_d;
      fall_pend_q <= fall_pend_d;
      new_frame_q <= new_frame_d;
      wen_q       <= wen_d;
      wrst_q      <= wrst_d;
      timeout_q   <= timeout_d;
      count_q     <= count_d;
    end
  end

  assign new_frame   = new_frame_q;
  assign fifo_wen    = wen_q;
  assign fifo_wrst   = wrst_q;
  assign timeout     = timeout_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_ov_write.sv
// Testbench for ov_write: directed vector table, hand sequences and randomized run.
// Latency: n/a.
// Backpressure: n/a.
module tb_ov_write;

  localparam int P_WRST = 4;
  localparam int P_SKIP = 2;
  localparam int P_TO   = 1000;

  logic       clk_25MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       initialized = 1'b0;
  logic       vsync = 1'b0;
  logic       frame_read = 1'b0;
  logic       new_frame, fifo_wen, fifo_wrst, timeout;
  logic [7:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  int mdl_bad = 0;
  bit mdl_en = 1'b0;

  ov_write #(.WRST_CYCLES(P_WRST), .SKIP_FRAMES(P_SKIP), .TIMEOUT(P_TO)) dut (
    .clk_25MHz   (clk_25MHz),
    .rst_n       (rst_n),
    .initialized (initialized),
    .vsync       (vsync),
    .frame_read  (frame_read),
    .new_frame   (new_frame),
    .fifo_wen    (fifo_wen),
    .fifo_wrst   (fifo_wrst),
    .timeout     (timeout),
    .frame_count (frame_count)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25MHz);
  endtask

  // ---------------- behavioural reference model ----------------
  // Pin history holds the VSYNC level seen at the last three clock edges (oldest first);
  // an edge becomes visible to the controller two edges after it is first sampled.
  bit pin_hist[$];
  int m_skip, m_wrst_left, m_quiet, m_count;
  bit m_wait, m_arm, m_fallseen, m_capt, m_ready, m_busy, m_to;
  bit r_rise, r_fall, r_active, r_expire;

  task automatic m_clear_flags();
    m_wait = 0; m_arm = 0; m_fallseen = 0; m_capt = 0; m_ready = 0; m_busy = 0;
    m_wrst_left = 0; m_quiet = 0;
  endtask

  always @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      pin_hist.delete();
      for (int i = 0; i < 3; i++) pin_hist.push_back(1'b0);
      m_clear_flags();
      m_skip = P_SKIP; m_count = 0; m_to = 0;
    end else begin
      r_rise = pin_hist[1] && !pin_hist[0];
      r_fall = !pin_hist[1] && pin_hist[0];
      void'(pin_hist.pop_front());
      pin_hist.push_back(vsync);
      m_to = 0;
      r_active = m_wait || m_arm || m_capt;
      r_expire = r_active && !r_rise && !r_fall && (m_quiet == P_TO - 1);
      m_quiet = (r_active && !r_rise && !r_fall) ? m_quiet + 1 : 0;
      if (!initialized) begin
        m_clear_flags();
        m_skip = P_SKIP;
      end else if (m_wait) begin
        if (r_rise) begin
          if (m_skip > 0) m_skip--;
          else begin m_wait = 0; m_wrst_left = P_WRST; end
        end else if (r_expire) begin
          m_clear_flags(); m_to = 1;
        end
      end else if (m_wrst_left > 0) begin
        if (r_fall) m_fallseen = 1;
        m_wrst_left--;
        if (m_wrst_left == 0) m_arm = 1;
      end else if (m_arm) begin
        if (r_fall || m_fallseen) begin
          m_arm = 0; m_fallseen = 0; m_capt = 1; m_quiet = 0;
        end else if (r_expire) begin
          m_clear_flags(); m_to = 1;
        end
      end else if (m_capt) begin
        if (r_rise) begin
          m_capt = 0; m_ready = 1; m_count = (m_count + 1) % 256;
        end else if (r_expire) begin
          m_clear_flags(); m_to = 1;
        end
      end else if (m_ready) begin
        if (!frame_read) begin m_ready = 0; m_busy = 1; end
      end else if (m_busy) begin
        if (frame_read) m_busy = 0;
      end else if (frame_read) begin
        m_wait = 1;
      end
    end
  end

  // Every cycle, compare all outputs against the model (capped to keep the log readable).
  always @(negedge clk_25MHz) begin
    if (mdl_en && mdl_bad < 10) begin
      n_cmp++;
      if ({new_frame, fifo_wen, fifo_wrst, timeout, frame_count} !==
          {m_ready, m_capt, (m_wrst_left == 0), m_to, 8'(m_count)}) begin
        n_bad++;
        mdl_bad++;
        $display("FAIL model t=%0t: nf/wen/wrst/to=%b%b%b%b fc=%0d, expected %b%b%b%b fc=%0d",
                 $time, new_frame, fifo_wen, fifo_wrst, timeout, frame_count,
                 m_ready, m_capt, (m_wrst_left == 0), m_to, m_count);
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    bit ini; bit fr; bit vs; int n;
    bit nf; bit wen; bit wrst; int fc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int cnt;
    int vs_left;

    // Nominal capture with two skipped frames, then the reader handshake.
    tbl[0]  = '{ini:1, fr:1, vs:0, n:20,  nf:0, wen:0, wrst:1, fc:0};
    tbl[1]  = '{ini:1, fr:1, vs:1, n:10,  nf:0, wen:0, wrst:1, fc:0};
    tbl[2]  = '{ini:1, fr:1, vs:0, n:100, nf:0, wen:0, wrst:1, fc:0};
    tbl[3]  = '{ini:1, fr:1, vs:1, n:10,  nf:0, wen:0, wrst:1, fc:0};
    tbl[4]  = '{ini:1, fr:1, vs:0, n:100, nf:0, wen:0, wrst:1, fc:0};
    tbl[5]  = '{ini:1, fr:1, vs:1, n:3,   nf:0, wen:0, wrst:0, fc:0};
    tbl[6]  = '{ini:1, fr:1, vs:1, n:3,   nf:0, wen:0, wrst:0, fc:0};
    tbl[7]  = '{ini:1, fr:1, vs:0, n:1,   nf:0, wen:0, wrst:1, fc:0};
    tbl[8]  = '{ini:1, fr:1, vs:0, n:2,   nf:0, wen:1, wrst:1, fc:0};
    tbl[9]  = '{ini:1, fr:1, vs:0, n:100, nf:0, wen:1, wrst:1, fc:0};
    tbl[10] = '{ini:1, fr:1, vs:1, n:2,   nf:0, wen:1, wrst:1, fc:0};
    tbl[11] = '{ini:1, fr:1, vs:1, n:1,   nf:1, wen:0, wrst:1, fc:1};
    tbl[12] = '{ini:1, fr:1, vs:0, n:10,  nf:1, wen:0, wrst:1, fc:1};
    tbl[13] = '{ini:1, fr:0, vs:0, n:1,   nf:0, wen:0, wrst:1, fc:1};
    tbl[14] = '{ini:1, fr:0, vs:1, n:20,  nf:0, wen:0, wrst:1, fc:1};
    tbl[15] = '{ini:1, fr:0, vs:0, n:980, nf:0, wen:0, wrst:1, fc:1};
    tbl[16] = '{ini:1, fr:1, vs:0, n:5,   nf:0, wen:0, wrst:1, fc:1};

    // Reset state.
    tick(2);
    chk("reset new_frame", 32'(new_frame), 0);
    chk("reset fifo_wen", 32'(fifo_wen), 0);
    chk("reset fifo_wrst", 32'(fifo_wrst), 1);
    chk("reset timeout", 32'(timeout), 0);
    chk("reset frame_count", 32'(frame_count), 0);
    rst_n = 1'b1;
    mdl_en = 1'b1;

    for (int i = 0; i < 17; i++) begin
      initialized = tbl[i].ini;
      frame_read  = tbl[i].fr;
      vsync       = tbl[i].vs;
      tick(tbl[i].n);
      chk($sformatf("vec%0d new_frame", i), 32'(new_frame), int'(tbl[i].nf));
      chk($sformatf("vec%0d fifo_wen", i), 32'(fifo_wen), int'(tbl[i].wen));
      chk($sformatf("vec%0d fifo_wrst", i), 32'(fifo_wrst), int'(tbl[i].wrst));
      chk($sformatf("vec%0d frame_count", i), 32'(frame_count), tbl[i].fc);
    end

    // Short VSYNC pulse: the fall arrives during the pointer reset and is latched.
    vsync = 1'b1; tick(2);
    vsync = 1'b0; tick(1);
    chk("short wrst low", 32'(fifo_wrst), 0);
    tick(3);
    chk("short wrst held", 32'(fifo_wrst), 0);
    chk("short wen waits", 32'(fifo_wen), 0);
    tick(1);
    chk("short wrst released", 32'(fifo_wrst), 1);
    chk("short wen not yet", 32'(fifo_wen), 0);
    tick(1);
    chk("short latched fall wen", 32'(fifo_wen), 1);

    // initialized dropped mid-capture, then two frames skipped again.
    tick(20);
    chk("init-drop pre wen", 32'(fifo_wen), 1);
    initialized = 1'b0; tick(1);
    chk("init-drop wen", 32'(fifo_wen), 0);
    chk("init-drop new_frame", 32'(new_frame), 0);
    chk("init-drop wrst", 32'(fifo_wrst), 1);
    tick(5);
    initialized = 1'b1; tick(5);
    for (int p = 0; p < 2; p++) begin
      vsync = 1'b1; tick(6);
      vsync = 1'b0; tick(100);
      chk($sformatf("reskip%0d wrst", p), 32'(fifo_wrst), 1);
      chk($sformatf("reskip%0d wen", p), 32'(fifo_wen), 0);
    end
    vsync = 1'b1; tick(3);
    chk("reskip capture wrst", 32'(fifo_wrst), 0);
    tick(3);
    vsync = 1'b0; tick(3);
    chk("reskip capture wen", 32'(fifo_wen), 1);

    // Watchdog: VSYNC stops while capturing.
    cnt = 0;
    while (cnt < 3 * P_TO && timeout !== 1'b1) begin
      tick(1);
      cnt++;
    end
    chk("watchdog cycles", 32'(cnt), P_TO);
    chk("watchdog wen", 32'(fifo_wen), 0);
    chk("watchdog wrst", 32'(fifo_wrst), 1);
    chk("watchdog frame_count", 32'(frame_count), 1);
    tick(1);
    chk("watchdog pulse width", 32'(timeout), 0);

    // Asynchronous reset in the middle of a capture.
    tick(3);
    vsync = 1'b1; tick(6);
    vsync = 1'b0; tick(3);
    chk("areset pre wen", 32'(fifo_wen), 1);
    chk("areset pre frame_count", 32'(frame_count), 1);
    #10;
    rst_n = 1'b0;
    #1;
    chk("areset wen", 32'(fifo_wen), 0);
    chk("areset wrst", 32'(fifo_wrst), 1);
    chk("areset frame_count", 32'(frame_count), 0);
    chk("areset new_frame", 32'(new_frame), 0);
    tick(2);
    rst_n = 1'b1;

    // Randomized run: jittery VSYNC with occasional stalls, random reader, rare config loss.
    vs_left = 10;
    for (int c = 0; c < 20000; c++) begin
      tick(1);
      if (vs_left == 0) begin
        vsync = ~vsync;
        if (vsync) vs_left = $urandom_range(1, 12);
        else if ($urandom_range(0, 15) == 0) vs_left = $urandom_range(1000, 1400);
        else vs_left = $urandom_range(20, 300);
      end else begin
        vs_left--;
      end
      if (frame_read && new_frame && $urandom_range(0, 7) == 0) frame_read = 1'b0;
      else if (!frame_read && $urandom_range(0, 49) == 0) frame_read = 1'b1;
      if (initialized && $urandom_range(0, 3999) == 0) initialized = 1'b0;
      else if (!initialized && $urandom_range(0, 19) == 0) initialized = 1'b1;
    end

    mdl_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ov_write.md
Name: ov_write

Overview:
- Write-side controller for the camera-to-FIFO path. It gates OV7670 frame data into the AL422 FIFO by driving the FIFO write-enable and write-reset from the camera VSYNC timing.
- When a complete frame is stored, it signals it on new_frame.
- It then holds off the next capture until the FIFO read controller has drained the frame, handshaking on new_frame/frame_read.
- The FIFO write clock is the camera PCLK, wired directly outside this block; this block only controls wen and wrst.

Parameters:
- WRST_CYCLES, 4: clk_25MHz cycles that fifo_wrst is held low.
- SKIP_FRAMES, 2: VSYNC frames discarded after initialized rises, before the first capture.
- TIMEOUT, 2500000: clk_25MHz cycles (100 ms) without an expected VSYNC edge before the capture is aborted.

Ports:
- clk_25MHz  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous active-low reset.
- initialized  in  1  camera SCCB configuration complete; level.
- vsync  in  1  camera VSYNC, asynchronous to clk_25MHz; high during the vertical blank pulse.
- frame_read  in  1  from the read controller; high = idle, low = reading a frame.
- new_frame  out  1  high = a complete frame is in the FIFO, awaiting the reader.
- fifo_wen  out  1  AL422 write enable, active high.
- fifo_wrst  out  1  AL422 write-pointer reset, active low.
- timeout  out  1  one-cycle pulse when a capture is aborted by the watchdog.
- frame_count  out  8  number of frames completed; wraps 255→0.

Behaviour:
- Interface: one clock, clk_25MHz. Reset rst_n is asynchronous, active-low.
- Reset values: new_frame=0, fifo_wen=0, fifo_wrst=1, timeout=0, frame_count=0, state=IDLE, skip counter=SKIP_FRAMES, watchdog=0.
- VSYNC input path:
  - vsync passes through a 2-FF synchronizer, then a third register for edge detection.
  - vs_rise and vs_fall are single-cycle strobes, 3 clk_25MHz cycles after the pin edge.
- States:
  - IDLE:
    - If initialized && frame_read, go to SYNC.
  - SYNC:
    - On vs_rise with skip counter ≠ 0: decrement the counter and stay.
    - On vs_rise with skip counter = 0: drive fifo_wrst=0, load the hold counter, go to WRST.
  - WRST:
    - Count WRST_CYCLES cycles.
    - Then drive fifo_wrst=1 and go to ARM.
    - A vs_fall during WRST is not lost; it is latched and consumed in ARM.
  - ARM:
    - On vs_fall (or the latched fall): fifo_wen=1 on the next edge, clear the watchdog, go to CAPT.
  - CAPT:
    - On vs_rise: fifo_wen=0, frame_count+1, new_frame=1, go to READY.
  - READY:
    - Hold new_frame=1 until frame_read is sampled low.
    - Then new_frame=0, go to BUSY.
  - BUSY:
    - Wait for frame_read high, then go to IDLE.
    - This prevents overwriting the FIFO while the reader is active.
- Skip counter:
  - Reloads to SKIP_FRAMES only on reset or when initialized falls.
  - SKIP_FRAMES=0 captures on the first vs_rise.
- Watchdog (22-bit counter):
  - Runs in SYNC, ARM and CAPT.
  - Clears on every vs_rise or vs_fall.
  - On reaching TIMEOUT: fifo_wen=0, fifo_wrst=1, pulse timeout for one cycle, go to IDLE. frame_count is unchanged.
- initialized falling in any state:
  - Next cycle: fifo_wen=0, fifo_wrst=1, new_frame=0, go to IDLE.
- Asynchronous reset mid-capture: immediately fifo_wen=0 and fifo_wrst=1.
- Simultaneous events:
  - vs_rise and watchdog expiry in the same cycle: vs_rise wins.
  - frame_read low already at READY entry: new_frame stays high for exactly one cycle.
- fifo_wen only ever transitions in ARM→CAPT (rise) and CAPT→READY or abort (fall). It is never high outside CAPT.

Decomposition:
- Shared package (ov_pkg):
  - state encoding constants;
  - frame geometry (320×240×2 bytes);
  - default TIMEOUT value, also reused by the read controller.
- One natural sub-module: sync_edge, a 2-FF synchronizer plus edge detector producing rise/fall strobes; reusable for href/pclk monitoring.

Test Plan:
1. Nominal capture, SKIP_FRAMES=2.
   - Stimulus: initialized=1; frame_read=1; VSYNC period 33 ms with 0.4 ms pulse.
   - Response: fifo_wrst low for 4 cycles after the 3rd vs_rise; fifo_wen high from the following vs_fall+1 to the next vs_rise+1; new_frame=1; frame_count=1.
2. Reader handshake.
   - Stimulus: drop frame_read 10 cycles after new_frame rises; hold low 1000 cycles, then raise.
   - Response: new_frame falls 1 cycle after frame_read low; no fifo_wrst or fifo_wen activity until frame_read is high again; the next capture starts at the following vs_rise.
3. Watchdog, TIMEOUT=1000.
   - Stimulus: stop VSYNC toggling while in CAPT.
   - Response: fifo_wen=0 and a one-cycle timeout pulse exactly 1000 cycles after the last edge; state IDLE; frame_count unchanged.
4. initialized deasserted mid-CAPT.
   - Response: fifo_wen=0 next cycle; new_frame stays 0; after re-assertion, 2 frames are skipped again.
5. Asynchronous reset.
   - Stimulus: assert rst_n low mid-CAPT, between clock edges.
   - Response: fifo_wen=0, fifo_wrst=1, frame_count=0 immediately, without waiting for a clock edge.
6. Short VSYNC pulse.
   - Stimulus: pulse narrower than WRST_CYCLES (2 cycles high).
   - Response: the fall is latched; fifo_wen rises right after WRST completes.
